// File: rtl/gcd_pkg.sv
// gcd_pkg: shared types and helpers for the GCD engine.
// State encoding, default legacy opcode and operand checks.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [5:0] GCD_OP_DEFAULT = 6'b101000;

  function automatic logic is_zero_pair(
    input logic [63:0] a,
    input logic [63:0] b
  );
    return (a == 64'd0) && (b == 64'd0);
  endfunction

endpackage

// File: rtl/gcd_unit_if.sv
// gcd_unit_if: operand/result handshake bundle of the GCD engine.
// master drives operands and consumes results; slave is the engine.
interface gcd_unit_if #(
  parameter int WIDTH = 11
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             zero_err;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, y, busy, zero_err
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, y, busy, zero_err
  );
endinterface

// File: rtl/gcd_step.sv
// gcd_step: next (ra, rb) and completion for one RUN cycle.
// Subtract-swap by default; binary (Stein) steps with GCD_BINARY_EN.
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = 11
) (
  input  logic [WIDTH-1:0]         ra,
  input  logic [WIDTH-1:0]         rb,
`ifdef GCD_BINARY_EN
  input  logic [$clog2(WIDTH)-1:0] k,
  output logic [$clog2(WIDTH)-1:0] nk,
`endif
  output logic [WIDTH-1:0]         nra,
  output logic [WIDTH-1:0]         nrb,
  output logic [WIDTH-1:0]         res,
  output logic                     done
);

`ifdef GCD_BINARY_EN
  logic z_a, z_b, nz, e_a, e_b;

  assign z_a = (ra == '0);
  assign z_b = (rb == '0);
  assign nz  = ~z_a & ~z_b;
  assign e_a = ~ra[0];
  assign e_b = ~rb[0];

  // one Stein step: strip shared twos into k, then odd-odd difference
  always_comb begin
    nra  = ra;
    nrb  = rb;
    nk   = k;
    res  = '0;
    done = 1'b0;
    unique case (1'b1)
      z_b: begin
        done = 1'b1;
        res  = ra << k;
      end
      (~z_b & z_a): begin
        done = 1'b1;
        res  = rb << k;
      end
      (nz & e_a & e_b): begin
        nra = ra >> 1;
        nrb = rb >> 1;
        nk  = k + 1'b1;
      end
      (nz & e_a & ~e_b): nra = ra >> 1;
      (nz & ~e_a & e_b): nrb = rb >> 1;
      default: begin
        if (ra >= rb) nra = ra - rb;
        else          nrb = rb - ra;
      end
    endcase
  end
`else
  logic z_b, ge;

  assign z_b = (rb == '0);
  assign ge  = ~z_b & (ra >= rb);

  // one subtract-swap step; the smaller operand never underflows
  always_comb begin
    nra  = ra;
    nrb  = rb;
    res  = '0;
    done = 1'b0;
    unique case (1'b1)
      z_b: begin
        done = 1'b1;
        res  = ra;
      end
      ge: nra = ra - rb;
      default: begin
        nra = rb;
        nrb = ra;
      end
    endcase
  end
`endif

endmodule

// File: rtl/gcd_unit.sv
// gcd_unit: iterative GCD engine with valid/ready handshake and ALU trigger.
// Define GCD_BINARY_EN to run binary (Stein) steps instead of subtract-swap.
module gcd_unit
  import gcd_pkg::*;
#(
  parameter int               WIDTH  = 11,
  parameter int               SEL_W  = 6,
  parameter logic [SEL_W-1:0] OP_GCD = SEL_W'(GCD_OP_DEFAULT)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [SEL_W-1:0] sel,
  input  logic             carry_in,
  gcd_unit_if.slave        bus
);

  state_t           state;
  logic [WIDTH-1:0] ra, rb;
  logic [WIDTH-1:0] nra, nrb, res;
  logic             step_done;
  logic [WIDTH-1:0] y_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             zero_err_q;
  logic             in_ready_q;
  logic             zero_pair;
  logic             d0, d1, d2;
  logic             leg_start;
  logic             start;

`ifdef GCD_BINARY_EN
  localparam int KW = $clog2(WIDTH);
  logic [KW-1:0] k, nk;
`endif

  assign leg_start = d1 & ~d2;
  assign start     = (state == IDLE) &
                     ((bus.in_valid & in_ready_q) | leg_start);

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.busy      = busy_q;
  assign bus.zero_err  = zero_err_q;

  gcd_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .ra   (ra),
    .rb   (rb),
`ifdef GCD_BINARY_EN
    .k    (k),
    .nk   (nk),
`endif
    .nra  (nra),
    .nrb  (nrb),
    .res  (res),
    .done (step_done)
  );

  // legacy carry strobe shifts only while the GCD opcode is selected
  always_ff @(posedge clock) begin
    if (!reset) begin
      d0 <= 1'b0;
      d1 <= 1'b0;
      d2 <= 1'b0;
    end else if (sel == OP_GCD) begin
      d0 <= carry_in;
      d1 <= d0;
      d2 <= d1;
    end
  end

  // job FSM with registered handshake and result outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      ra          <= '0;
      rb          <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      zero_err_q  <= 1'b0;
      zero_pair   <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef GCD_BINARY_EN
      k           <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            ra         <= bus.a;
            rb         <= bus.b;
            zero_pair  <= is_zero_pair(64'(bus.a), 64'(bus.b));
            busy_q     <= 1'b1;
            in_ready_q <= 1'b0;
            state      <= RUN;
`ifdef GCD_BINARY_EN
            k          <= '0;
`endif
          end
        end
        RUN: begin
          ra <= nra;
          rb <= nrb;
`ifdef GCD_BINARY_EN
          k  <= nk;
`endif
          if (step_done) begin
            y_q         <= res;
            out_valid_q <= 1'b1;
            zero_err_q  <= zero_pair;
            busy_q      <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            y_q         <= '0;
            out_valid_q <= 1'b0;
            zero_err_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_unit.sv
// tb_gcd_unit: directed and random checks of gcd_unit.
// Results are compared against a Euclid reference through a queue.
module tb_gcd_unit;

  localparam int         W    = 11;
  localparam int         MAXC = 3000;
  localparam logic [5:0] OPC  = 6'b101000;

  typedef struct {
    logic [W-1:0] y;
    logic         ze;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] sel;
  logic       carry_in;
  int         total = 0;
  int         bad   = 0;
  int         lat;
  exp_t       sb[$];

  gcd_unit_if #(.WIDTH(W)) bus ();

  gcd_unit #(
    .WIDTH  (W),
    .SEL_W  (6),
    .OP_GCD (OPC)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .sel      (sel),
    .carry_in (carry_in),
    .bus      (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [W-1:0] gcd_ref(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [W-1:0] x = a;
    logic [W-1:0] z = b;
    logic [W-1:0] t;
    while (z != '0) begin
      t = x % z;
      x = z;
      z = t;
    end
    return x;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.y  = gcd_ref(a, b);
    e.ze = (a == '0) && (b == '0);
    sb.push_back(e);
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < MAXC) begin
      tick();
      n++;
    end
    chk("send_rdy", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    push(a, b);
  endtask

  task automatic wait_done(input string tag, output int l);
    exp_t e;
    int   n = 0;
    while (!bus.out_valid && n < MAXC) begin
      tick();
      n++;
    end
    l = n;
    chk({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_y"}, 32'(bus.y), 32'(e.y));
      chk({tag, "_ze"}, 32'(bus.zero_err), 32'(e.ze));
    end
  endtask

  initial begin
    logic         seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    reset         = 1'b0;
    sel           = 6'd0;
    carry_in      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();

    chk("rst_vld", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_y", 32'(bus.y), 32'd0);
    chk("rst_ze", 32'(bus.zero_err), 32'd0);
    chk("rst_rdy", 32'(bus.in_ready), 32'd1);

    send(11'd12, 11'd8);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    chk("t1_rdy", 32'(bus.in_ready), 32'd0);
    lat = 0;
    wait_done("t1", lat);
`ifndef GCD_BINARY_EN
    chk("t1_lat", 32'(lat), 32'd6);
`endif

    send(11'd0, 11'd0);
    wait_done("t2z", lat);
    send(11'd0, 11'd9);
    wait_done("t2a", lat);
`ifndef GCD_BINARY_EN
    chk("t2a_lat", 32'(lat), 32'd2);
`endif
    send(11'd9, 11'd0);
    wait_done("t2b", lat);
    chk("t2b_lat", 32'(lat), 32'd1);
    tick();

    sel = OPC;
    tick();
    tick();
    tick();
    bus.a    = 11'd35;
    bus.b    = 11'd21;
    carry_in = 1'b1;
    push(11'd35, 11'd21);
    wait_done("t3", lat);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.busy || bus.out_valid) seen = 1'b1;
    end
    chk("t3_once", 32'(seen), 32'd0);

    sel      = 6'd3;
    carry_in = 1'b0;
    tick();
    carry_in = 1'b1;
    seen     = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.busy || bus.out_valid) seen = 1'b1;
    end
    chk("t3_nosel", 32'(seen), 32'd0);
    carry_in = 1'b0;

    bus.out_ready = 1'b0;
    send(11'd12, 11'd8);
    wait_done("t4", lat);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_vld", 32'(bus.out_valid), 32'd1);
      chk("t4_y", 32'(bus.y), 32'd4);
      chk("t4_rdy", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("t4_rel_vld", 32'(bus.out_valid), 32'd0);
    chk("t4_rel_rdy", 32'(bus.in_ready), 32'd1);
    chk("t4_rel_y", 32'(bus.y), 32'd0);

    send(11'd1000, 11'd3);
    for (int i = 0; i < 5; i++) tick();
    chk("t5_busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    sb.delete();
    chk("t5_vld", 32'(bus.out_valid), 32'd0);
    chk("t5_busy0", 32'(bus.busy), 32'd0);
    chk("t5_y", 32'(bus.y), 32'd0);
    chk("t5_ze", 32'(bus.zero_err), 32'd0);
    chk("t5_rdy", 32'(bus.in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.out_valid || bus.busy) seen = 1'b1;
    end
    chk("t5_quiet", 32'(seen), 32'd0);
    send(11'd1000, 11'd3);
    wait_done("t5", lat);

    sel = OPC;
    tick();
    tick();
    tick();
    send(11'd1000, 11'd7);
    tick();
    carry_in = 1'b1;
    tick();
    tick();
    tick();
    carry_in = 1'b0;
    wait_done("t6leg", lat);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.busy || bus.out_valid) seen = 1'b1;
    end
    chk("t6_leg_drop", 32'(seen), 32'd0);
    sel = 6'd0;

    send(11'd2047, 11'd1);
    wait_done("t6wc", lat);
`ifndef GCD_BINARY_EN
    chk("t6wc_lat", 32'(lat), 32'd2049);
`endif

    for (int i = 0; i < 500; i++) begin
      ra = W'($urandom_range(0, 2047));
      rb = W'($urandom_range(0, 2047));
      if (i % 4 == 1) rb = W'($urandom_range(0, 15));
      if (i % 8 == 3) ra = rb * W'($urandom_range(1, 5));
      send(ra, rb);
      wait_done("t6r", lat);
    end
    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
